// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit CPU sequencer: control word, ALU flags,
// sequencer states, opcode values and the idle control word.
package cpu_pkg;

    // One strobe per datapath control line, asserted for a single cycle.
    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic mar_ld;
        logic ram_rd;
        logic ram_wr;
        logic ir_ld;
        logic ir_out;
        logic a_ld;
        logic a_out;
        logic b_ld;
        logic alu_out;
        logic alu_sub;
        logic flag_en;
        logic flag_clf;
        logic force_carry;
        logic jump;
        logic out_ld;
    } struct_ctrl_word_t;

    // Registered ALU flags as seen from the flag register.
    typedef struct packed {
        logic carry;
        logic zero;
    } struct_alu_flag_t;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        EXEC0  = 3'd2,
        EXEC1  = 3'd3,
        EXEC2  = 3'd4,
        HALT   = 3'd5,
        FAULT  = 3'd6
    } struct_seq_state_e;

    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_LDA = 4'h1;
    localparam logic [3:0] OPC_ADD = 4'h2;
    localparam logic [3:0] OPC_SUB = 4'h3;
    localparam logic [3:0] OPC_STA = 4'h4;
    localparam logic [3:0] OPC_LDI = 4'h5;
    localparam logic [3:0] OPC_JMP = 4'h6;
    localparam logic [3:0] OPC_JC  = 4'h7;
    localparam logic [3:0] OPC_JZ  = 4'h8;
    localparam logic [3:0] OPC_ADC = 4'h9;
    localparam logic [3:0] OPC_CLF = 4'hA;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    localparam struct_ctrl_word_t CW_IDLE = '0;

endpackage

// File: rtl/seq_wait_timer.sv
// RAM read stall counter. Counts consecutive read cycles without ready and
// flags a timeout on the stall cycle that brings the count to WAIT_LIMIT.
// A ready arriving on that same cycle wins, so no timeout is raised.
module seq_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic rd_active,
    input  logic rdy,
    output logic timeout
);

    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count only while a read is stalling; any ready or non-read cycle clears.
    always_comb begin
        cnt_d   = 8'd0;
        timeout = 1'b0;
        if (rd_active && !rdy) begin
            cnt_d   = cnt_q + 8'd1;
            timeout = (cnt_q >= LIMIT_M1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_exec_seq.sv
// Instruction sequencer for the 8-bit CPU. Walks each instruction through
// FETCH0/FETCH1 and up to three execute states, emitting one control word
// per cycle. Stalls reads on RAM ready and faults when the wait timer expires.
// Build option SINGLE_STEP_EN adds istep_mode/istep: in step mode the FSM
// parks in FETCH0 until a cycle with istep=1.
module cpu_exec_seq
    import cpu_pkg::*;
#(
    parameter int OPC_W      = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic [OPC_W-1:0]  iopcode,
    input  struct_alu_flag_t  iflag,
    input  logic              iram_rdy,
`ifdef SINGLE_STEP_EN
    input  logic              istep_mode,
    input  logic              istep,
`endif
    output struct_ctrl_word_t ocw,
    output struct_seq_state_e ostate,
    output logic              ohalt,
    output logic              ofault
);

    struct_seq_state_e state_q;
    struct_seq_state_e state_d;
    struct_ctrl_word_t cw;
    logic [3:0]        opc;
    logic              rd_active;
    logic              timeout;
    logic              step_ok;

    assign opc = iopcode[3:0];

`ifdef SINGLE_STEP_EN
    assign step_ok = !istep_mode || istep;
`else
    assign step_ok = 1'b1;
`endif

    seq_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk       (iclk),
        .rst       (irst),
        .rd_active (rd_active),
        .rdy       (iram_rdy),
        .timeout   (timeout)
    );

    // Next-state and control word decode; reset forces an idle word.
    always_comb begin
        state_d   = state_q;
        cw        = CW_IDLE;
        rd_active = 1'b0;
        case (state_q)
            FETCH0: begin
                if (step_ok) begin
                    cw.pc_out = 1'b1;
                    cw.mar_ld = 1'b1;
                    state_d   = FETCH1;
                end
            end
            FETCH1: begin
                rd_active = 1'b1;
                cw.ram_rd = 1'b1;
                if (iram_rdy) begin
                    cw.ir_ld  = 1'b1;
                    cw.pc_inc = 1'b1;
                    state_d   = EXEC0;
                end else if (timeout) begin
                    state_d = FAULT;
                end
            end
            EXEC0: begin
                state_d = FETCH0;
                case (opc)
                    OPC_LDA, OPC_ADD, OPC_SUB, OPC_ADC, OPC_STA: begin
                        cw.ir_out = 1'b1;
                        cw.mar_ld = 1'b1;
                        state_d   = EXEC1;
                    end
                    OPC_LDI: begin
                        cw.ir_out = 1'b1;
                        cw.a_ld   = 1'b1;
                    end
                    OPC_JMP: begin
                        cw.ir_out = 1'b1;
                        cw.jump   = 1'b1;
                    end
                    OPC_JC: begin
                        cw.ir_out = 1'b1;
                        cw.jump   = iflag.carry;
                    end
                    OPC_JZ: begin
                        cw.ir_out = 1'b1;
                        cw.jump   = iflag.zero;
                    end
                    OPC_CLF: cw.flag_clf = 1'b1;
                    OPC_OUT: begin
                        cw.a_out  = 1'b1;
                        cw.out_ld = 1'b1;
                    end
                    OPC_HLT: state_d = HALT;
                    default: state_d = FETCH0;
                endcase
            end
            EXEC1: begin
                state_d = FETCH0;
                case (opc)
                    OPC_LDA, OPC_ADD, OPC_SUB, OPC_ADC: begin
                        rd_active = 1'b1;
                        cw.ram_rd = 1'b1;
                        state_d   = EXEC1;
                        if (iram_rdy) begin
                            if (opc == OPC_LDA) begin
                                cw.a_ld = 1'b1;
                                state_d = FETCH0;
                            end else begin
                                cw.b_ld = 1'b1;
                                state_d = EXEC2;
                            end
                        end else if (timeout) begin
                            state_d = FAULT;
                        end
                    end
                    OPC_STA: begin
                        cw.a_out  = 1'b1;
                        cw.ram_wr = 1'b1;
                    end
                    default: state_d = FETCH0;
                endcase
            end
            EXEC2: begin
                cw.alu_out     = 1'b1;
                cw.a_ld        = 1'b1;
                cw.flag_en     = 1'b1;
                cw.alu_sub     = (opc == OPC_SUB);
                cw.force_carry = (opc == OPC_ADD) || (opc == OPC_SUB);
                state_d        = FETCH0;
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = FETCH0;
        endcase
        if (irst) begin
            cw      = CW_IDLE;
            state_d = FETCH0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= FETCH0;
        end else begin
            state_q <= state_d;
        end
    end

    assign ocw    = cw;
    assign ostate = state_q;
    assign ohalt  = !irst && ((state_q == HALT) || (state_q == FAULT));
    assign ofault = !irst && (state_q == FAULT);

endmodule

// File: tb/tb_cpu_exec_seq.sv
// Bench for cpu_exec_seq: directed scenarios plus random instruction streams
// checked cycle by cycle against a per-instruction expected trace built from
// the instruction timing rules.
module tb_cpu_exec_seq;
    import cpu_pkg::*;

    localparam int WAIT_LIMIT = 15;

    typedef struct packed {
        logic              rdy;
        struct_seq_state_e st;
        struct_ctrl_word_t cw;
    } exp_t;

    logic              iclk = 1'b0;
    logic              irst = 1'b1;
    logic [3:0]        iopcode = 4'h0;
    struct_alu_flag_t  iflag = '0;
    logic              iram_rdy = 1'b0;
`ifdef SINGLE_STEP_EN
    logic              istep_mode = 1'b0;
    logic              istep = 1'b0;
`endif
    struct_ctrl_word_t ocw;
    struct_seq_state_e ostate;
    logic              ohalt;
    logic              ofault;

    exp_t exp_q[$];
    bit   stopped;
    struct_seq_state_e stop_st;
    int   n_checks = 0;
    int   n_fail = 0;

    cpu_exec_seq #(.OPC_W(4), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .iclk     (iclk),
        .irst     (irst),
        .iopcode  (iopcode),
        .iflag    (iflag),
        .iram_rdy (iram_rdy),
`ifdef SINGLE_STEP_EN
        .istep_mode (istep_mode),
        .istep      (istep),
`endif
        .ocw      (ocw),
        .ostate   (ostate),
        .ohalt    (ohalt),
        .ofault   (ofault)
    );

    // Clock
    always #5 iclk = ~iclk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input struct_seq_state_e st, input struct_ctrl_word_t cw, input logic rdy);
        exp_t e;
        e.st  = st;
        e.cw  = cw;
        e.rdy = rdy;
        exp_q.push_back(e);
        if (st == HALT || st == FAULT) begin
            stopped = 1'b1;
            stop_st = st;
        end
    endfunction

    // A RAM read: 'stall' cycles without ready, then the ready cycle carrying
    // the extra strobes. Stalling WAIT_LIMIT cycles ends in FAULT instead.
    function automatic bit push_read(input struct_seq_state_e st, input struct_ctrl_word_t on_rdy, input int stall);
        struct_ctrl_word_t w;
        w = CW_IDLE;
        w.ram_rd = 1'b1;
        for (int k = 0; k < stall && k < WAIT_LIMIT; k++) push(st, w, 1'b0);
        if (stall >= WAIT_LIMIT) begin
            push(FAULT, CW_IDLE, rnd_bit());
            return 1'b0;
        end
        on_rdy.ram_rd = 1'b1;
        push(st, on_rdy, 1'b1);
        return 1'b1;
    endfunction

    // Expected per-cycle trace of one instruction starting in FETCH0.
    task automatic build(input logic [3:0] opc, input logic c, input logic z, input int sf, input int se);
        struct_ctrl_word_t w;
        exp_q.delete();
        stopped = 1'b0;
        iopcode = opc;
        iflag.carry = c;
        iflag.zero  = z;
        w = CW_IDLE; w.pc_out = 1'b1; w.mar_ld = 1'b1;
        push(FETCH0, w, rnd_bit());
        w = CW_IDLE; w.ir_ld = 1'b1; w.pc_inc = 1'b1;
        if (!push_read(FETCH1, w, sf)) return;
        w = CW_IDLE;
        case (opc)
            OPC_LDA, OPC_ADD, OPC_SUB, OPC_ADC, OPC_STA: begin
                w.ir_out = 1'b1; w.mar_ld = 1'b1;
                push(EXEC0, w, rnd_bit());
                w = CW_IDLE;
                if (opc == OPC_STA) begin
                    w.a_out = 1'b1; w.ram_wr = 1'b1;
                    push(EXEC1, w, rnd_bit());
                end else if (opc == OPC_LDA) begin
                    w.a_ld = 1'b1;
                    void'(push_read(EXEC1, w, se));
                end else begin
                    w.b_ld = 1'b1;
                    if (push_read(EXEC1, w, se)) begin
                        w = CW_IDLE;
                        w.alu_out = 1'b1; w.a_ld = 1'b1; w.flag_en = 1'b1;
                        w.alu_sub = (opc == OPC_SUB);
                        w.force_carry = (opc != OPC_ADC);
                        push(EXEC2, w, rnd_bit());
                    end
                end
            end
            OPC_LDI: begin w.ir_out = 1'b1; w.a_ld = 1'b1; push(EXEC0, w, rnd_bit()); end
            OPC_JMP: begin w.ir_out = 1'b1; w.jump = 1'b1; push(EXEC0, w, rnd_bit()); end
            OPC_JC:  begin w.ir_out = 1'b1; w.jump = c; push(EXEC0, w, rnd_bit()); end
            OPC_JZ:  begin w.ir_out = 1'b1; w.jump = z; push(EXEC0, w, rnd_bit()); end
            OPC_CLF: begin w.flag_clf = 1'b1; push(EXEC0, w, rnd_bit()); end
            OPC_OUT: begin w.a_out = 1'b1; w.out_ld = 1'b1; push(EXEC0, w, rnd_bit()); end
            OPC_HLT: begin push(EXEC0, w, rnd_bit()); push(HALT, CW_IDLE, rnd_bit()); end
            default: push(EXEC0, w, rnd_bit());
        endcase
    endtask

    // Drive and check the next n expected cycles.
    task automatic play(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            iram_rdy = e.rdy;
            @(negedge iclk);
            check_eq("state", 32'(ostate), 32'(e.st));
            check_eq("cw", 32'(ocw), 32'(e.cw));
            check_eq("halt", 32'(ohalt), 32'(e.st == HALT || e.st == FAULT));
            check_eq("fault", 32'(ofault), 32'(e.st == FAULT));
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [3:0] opc, input logic c, input logic z, input int sf, input int se);
        build(opc, c, z, sf, se);
        play(exp_q.size());
    endtask

    // Terminal states hold with an idle word until reset.
    task automatic hold_check(input struct_seq_state_e st, input int n);
        for (int i = 0; i < n; i++) begin
            iram_rdy = rnd_bit();
            @(negedge iclk);
            check_eq("hold_state", 32'(ostate), 32'(st));
            check_eq("hold_cw", 32'(ocw), 32'(CW_IDLE));
            check_eq("hold_halt", 32'(ohalt), 32'd1);
            check_eq("hold_fault", 32'(ofault), 32'(st == FAULT));
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic do_reset();
        irst = 1'b1;
        iram_rdy = rnd_bit();
        @(negedge iclk);
        check_eq("rst_cw", 32'(ocw), 32'(CW_IDLE));
        check_eq("rst_halt", 32'(ohalt), 32'd0);
        @(posedge iclk);
        #1;
        irst = 1'b0;
        check_eq("rst_state", 32'(ostate), 32'(FETCH0));
        check_eq("rst_ohalt", 32'(ohalt), 32'd0);
        check_eq("rst_ofault", 32'(ofault), 32'd0);
    endtask

    function automatic int pick_stall();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return WAIT_LIMIT;
        if (r == 1) return WAIT_LIMIT - 1;
        return $urandom_range(0, 3);
    endfunction

    // Main sequence
    initial begin
        logic [3:0] opc;
        @(posedge iclk);
        #1;
        do_reset();

        // ADD with RAM always ready, flags clear
        run_instr(OPC_ADD, 1'b0, 1'b0, 0, 0);
        // Conditional jumps on both flag values
        run_instr(OPC_JC, 1'b0, 1'b1, 0, 0);
        run_instr(OPC_JC, 1'b1, 1'b0, 0, 0);
        run_instr(OPC_JZ, 1'b1, 1'b0, 0, 0);
        run_instr(OPC_JZ, 1'b0, 1'b1, 0, 0);
        // LDA with a 3-cycle stall, then the ready-on-limit edge case
        run_instr(OPC_LDA, 1'b0, 1'b0, 0, 3);
        run_instr(OPC_LDA, 1'b0, 1'b0, 0, WAIT_LIMIT - 1);
        run_instr(OPC_SUB, 1'b0, 1'b0, 2, 1);
        run_instr(OPC_ADC, 1'b1, 1'b0, 1, 0);
        run_instr(OPC_STA, 1'b0, 1'b0, 0, 5);
        run_instr(OPC_CLF, 1'b1, 1'b1, 0, 0);
        // Timeout in EXEC1 and in FETCH1
        run_instr(OPC_LDA, 1'b0, 1'b0, 0, WAIT_LIMIT);
        hold_check(FAULT, 3);
        do_reset();
        run_instr(OPC_NOP, 1'b0, 1'b0, WAIT_LIMIT, 0);
        hold_check(FAULT, 2);
        do_reset();
        // Halt holds for 20 cycles, one reset cycle recovers
        run_instr(OPC_HLT, 1'b0, 1'b0, 0, 0);
        hold_check(HALT, 20);
        do_reset();
        // Reset landing in EXEC1 of an ADD
        build(OPC_ADD, 1'b0, 1'b0, 0, 0);
        play(3);
        exp_q.delete();
        do_reset();
        run_instr(OPC_NOP, 1'b0, 1'b0, 0, 0);

`ifdef SINGLE_STEP_EN
        istep_mode = 1'b1;
        istep = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iclk);
            check_eq("park_state", 32'(ostate), 32'(FETCH0));
            check_eq("park_cw", 32'(ocw), 32'(CW_IDLE));
            @(posedge iclk);
            #1;
        end
        istep = 1'b1;
        build(OPC_LDI, 1'b0, 1'b0, 0, 0);
        play(1);
        istep = 1'b0;
        play(exp_q.size());
        for (int i = 0; i < 3; i++) begin
            @(negedge iclk);
            check_eq("park2_state", 32'(ostate), 32'(FETCH0));
            check_eq("park2_cw", 32'(ocw), 32'(CW_IDLE));
            @(posedge iclk);
            #1;
        end
        istep_mode = 1'b0;
`endif

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            opc = 4'($urandom_range(0, 15));
            run_instr(opc, rnd_bit(), rnd_bit(), pick_stall(), pick_stall());
            if (stopped) begin
                hold_check(stop_st, 2);
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
